// File: rtl/lzs_token_parser.sv
// LZS bit-stream token parser: decodes literals, short/long copy offsets and the
// variable-length length code from the shifter's lookahead window into tokens.
module lzs_token_parser #(
    parameter int SHORT_OFF_W = 7,
    parameter int LONG_OFF_W  = 11,
    parameter int LEN_W       = 12,
    parameter int SW          = LONG_OFF_W + 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce_decode,
    input  logic [SW-1:0]         stream_data,
    input  logic                  stream_valid,
    output logic [3:0]            stream_width,
    output logic                  stream_ack,
    output logic                  tok_valid,
    input  logic                  tok_ready,
    output logic                  tok_copy,
    output logic [7:0]            tok_lit,
    output logic [LONG_OFF_W-1:0] tok_off,
    output logic [LEN_W-1:0]      tok_len,
    output logic                  all_end,
    output logic                  err
);

    typedef enum logic [2:0] {
        IDLE, TOKEN, LEN1, LEN2, LENX, EMIT, END, ERR
    } state_t;

    localparam logic [3:0]     W_LIT   = 4'd9;
    localparam logic [3:0]     W_SHORT = 4'(2 + SHORT_OFF_W);
    localparam logic [3:0]     W_LONG  = 4'(2 + LONG_OFF_W);
    localparam logic [LEN_W:0] LEN_MAX = {1'b0, {LEN_W{1'b1}}};

    state_t                  state_q, state_d;
    logic                    tok_valid_q, tok_valid_d;
    logic                    tok_copy_q, tok_copy_d;
    logic [7:0]              tok_lit_q, tok_lit_d;
    logic [LONG_OFF_W-1:0]   tok_off_q, tok_off_d;
    logic [LEN_W-1:0]        tok_len_q, tok_len_d;
    logic [LONG_OFF_W-1:0]   off_q, off_d;
    logic [LEN_W-1:0]        len_q, len_d;

    logic                    slot_free;
    logic [1:0]              len_code;
    logic [3:0]              nibble;
    logic [SHORT_OFF_W-1:0]  short_off;
    logic [LONG_OFF_W-1:0]   long_off;
    logic [LEN_W:0]          len_sum;

    // The slot may be drained and refilled in the same cycle.
    assign slot_free = !tok_valid_q || tok_ready;
    assign len_code  = stream_data[SW-1 -: 2];
    assign nibble    = stream_data[SW-1 -: 4];
    assign short_off = stream_data[SW-3 -: SHORT_OFF_W];
    assign long_off  = stream_data[SW-3 -: LONG_OFF_W];
    assign len_sum   = {1'b0, len_q} + {{(LEN_W-3){1'b0}}, nibble};

    assign tok_valid = tok_valid_q;
    assign tok_copy  = tok_copy_q;
    assign tok_lit   = tok_lit_q;
    assign tok_off   = tok_off_q;
    assign tok_len   = tok_len_q;
    assign all_end   = (state_q == END);
    assign err       = (state_q == ERR);

    always_comb begin
        state_d      = state_q;
        tok_valid_d  = tok_valid_q && !tok_ready;
        tok_copy_d   = tok_copy_q;
        tok_lit_d    = tok_lit_q;
        tok_off_d    = tok_off_q;
        tok_len_d    = tok_len_q;
        off_d        = off_q;
        len_d        = len_q;
        stream_ack   = 1'b0;
        stream_width = 4'd0;

        case (state_q)
            IDLE: if (ce_decode) state_d = TOKEN;
            TOKEN: if (stream_valid) begin
                if (!stream_data[SW-1]) begin
                    if (slot_free) begin
                        stream_ack   = 1'b1;
                        stream_width = W_LIT;
                        tok_valid_d  = 1'b1;
                        tok_copy_d   = 1'b0;
                        tok_lit_d    = stream_data[SW-2 -: 8];
                    end
                end else if (stream_data[SW-2]) begin
                    stream_ack   = 1'b1;
                    stream_width = W_SHORT;
                    if (short_off == '0) begin
                        state_d = END;
                    end else begin
                        off_d   = LONG_OFF_W'(short_off);
                        state_d = LEN1;
                    end
                end else if (long_off == '0) begin
                    state_d = ERR;
                end else begin
                    stream_ack   = 1'b1;
                    stream_width = W_LONG;
                    off_d        = long_off;
                    state_d      = LEN1;
                end
            end
            LEN1: if (stream_valid) begin
                stream_ack   = 1'b1;
                stream_width = 4'd2;
                if (len_code == 2'b11) begin
                    state_d = LEN2;
                end else begin
                    len_d   = LEN_W'(32'(len_code) + 2);
                    state_d = EMIT;
                end
            end
            // Codes 00..11 map to 5..8; only 8 continues into the nibble stage.
            LEN2: if (stream_valid) begin
                stream_ack   = 1'b1;
                stream_width = 4'd2;
                len_d        = LEN_W'(32'(len_code) + 5);
                state_d      = (len_code == 2'b11) ? LENX : EMIT;
            end
            LENX: if (stream_valid) begin
                if (len_sum > LEN_MAX) begin
                    state_d = ERR;
                end else begin
                    stream_ack   = 1'b1;
                    stream_width = 4'd4;
                    len_d        = len_sum[LEN_W-1:0];
                    if (nibble != 4'hF) state_d = EMIT;
                end
            end
            EMIT: if (slot_free) begin
                tok_valid_d = 1'b1;
                tok_copy_d  = 1'b1;
                tok_off_d   = off_q;
                tok_len_d   = len_q;
                state_d     = TOKEN;
            end
            END, ERR: if (!ce_decode) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tok_valid_q <= 1'b0;
            tok_copy_q  <= 1'b0;
            tok_lit_q   <= '0;
            tok_off_q   <= '0;
            tok_len_q   <= '0;
            off_q       <= '0;
            len_q       <= '0;
        end else begin
            state_q     <= state_d;
            tok_valid_q <= tok_valid_d;
            tok_copy_q  <= tok_copy_d;
            tok_lit_q   <= tok_lit_d;
            tok_off_q   <= tok_off_d;
            tok_len_q   <= tok_len_d;
            off_q       <= off_d;
            len_q       <= len_d;
        end
    end

endmodule

// File: tb/tb_lzs_token_parser.sv
// Scoreboard bench for lzs_token_parser: a bit-queue shifter model feeds two
// instances (default widths and LEN_W=5); expected tokens and ack widths are queued.
module tb_lzs_token_parser;

    localparam int SW = 13;

    typedef struct {
        logic        copy;
        logic [7:0]  lit;
        logic [10:0] off;
        logic [11:0] len;
    } tok_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce_decode;
    logic [SW-1:0] stream_data, stream_data1;
    logic          stream_valid, stream_valid1;
    logic [3:0]    stream_width, stream_width1;
    logic          stream_ack, stream_ack1;
    logic          tok_valid, tok_valid1;
    logic          tok_ready, tok_ready1;
    logic          tok_copy, tok_copy1;
    logic [7:0]    tok_lit, tok_lit1;
    logic [10:0]   tok_off, tok_off1;
    logic [11:0]   tok_len;
    logic [4:0]    tok_len1;
    logic          all_end, all_end1;
    logic          err, err1;

    tok_t exp_tok[$];
    int   exp_w0[$];
    int   exp_w1[$];
    bit   q0[$];
    bit   q1[$];
    int   tok_cycle[$];
    int   cycle = 0;
    int   check_count = 0;
    int   error_count = 0;
    int   ack0, ack1, span;
    logic [7:0] lits [3] = '{8'h41, 8'h42, 8'h43};

    always #5 clk = ~clk;

    lzs_token_parser u_dut (
        .clk(clk), .rst(rst), .ce_decode(ce_decode),
        .stream_data(stream_data), .stream_valid(stream_valid),
        .stream_width(stream_width), .stream_ack(stream_ack),
        .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_copy(tok_copy),
        .tok_lit(tok_lit), .tok_off(tok_off), .tok_len(tok_len),
        .all_end(all_end), .err(err)
    );

    lzs_token_parser #(.LEN_W(5)) u_dut_small (
        .clk(clk), .rst(rst), .ce_decode(ce_decode),
        .stream_data(stream_data1), .stream_valid(stream_valid1),
        .stream_width(stream_width1), .stream_ack(stream_ack1),
        .tok_valid(tok_valid1), .tok_ready(tok_ready1), .tok_copy(tok_copy1),
        .tok_lit(tok_lit1), .tok_off(tok_off1), .tok_len(tok_len1),
        .all_end(all_end1), .err(err1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic refreshStream();
        for (int i = 0; i < SW; i++) begin
            stream_data[SW-1-i]  = (i < q0.size()) ? q0[i] : 1'b0;
            stream_data1[SW-1-i] = (i < q1.size()) ? q1[i] : 1'b0;
        end
        stream_valid  = (q0.size() > 0);
        stream_valid1 = (q1.size() > 0);
    endtask

    task automatic applyStimulus(input int sel, input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            if (sel == 0) q0.push_back(bits[i]);
            else          q1.push_back(bits[i]);
        end
        refreshStream();
    endtask

    task automatic expectLit(input logic [7:0] b);
        tok_t t;
        t.copy = 1'b0; t.lit = b; t.off = '0; t.len = '0;
        exp_tok.push_back(t);
        exp_w0.push_back(9);
    endtask

    task automatic expectCopy(input logic [10:0] off, input logic [11:0] len);
        tok_t t;
        t.copy = 1'b1; t.lit = '0; t.off = off; t.len = len;
        exp_tok.push_back(t);
    endtask

    // Samples outputs on the falling edge, then pops acked bits after the rising edge.
    task automatic stepCycle();
        tok_t e;
        bit   b;
        @(negedge clk);
        cycle++;
        if (tok_valid && tok_ready) begin
            tok_cycle.push_back(cycle);
            if (exp_tok.size() == 0) begin
                checkOutput("tok_unexpected", 32'(tok_valid), 32'd0);
            end else begin
                e = exp_tok.pop_front();
                checkOutput("tok_copy", 32'(tok_copy), 32'(e.copy));
                if (e.copy) begin
                    checkOutput("tok_off", 32'(tok_off), 32'(e.off));
                    checkOutput("tok_len", 32'(tok_len), 32'(e.len));
                end else begin
                    checkOutput("tok_lit", 32'(tok_lit), 32'(e.lit));
                end
            end
        end
        checkOutput("small_tok_valid", 32'(tok_valid1), 32'd0);
        ack0 = stream_ack  ? int'(stream_width)  : 0;
        ack1 = stream_ack1 ? int'(stream_width1) : 0;
        if (stream_ack) begin
            if (exp_w0.size() == 0) checkOutput("ack_unexpected", 32'(stream_ack), 32'd0);
            else checkOutput("ack_width", 32'(stream_width), 32'(exp_w0.pop_front()));
        end
        if (stream_ack1) begin
            if (exp_w1.size() == 0) checkOutput("small_ack_unexpected", 32'(stream_ack1), 32'd0);
            else checkOutput("small_ack_width", 32'(stream_width1), 32'(exp_w1.pop_front()));
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < ack0 && q0.size() > 0; i++) b = q0.pop_front();
        for (int i = 0; i < ack1 && q1.size() > 0; i++) b = q1.pop_front();
        refreshStream();
    endtask

    task automatic waitDrain(input string tag);
        for (int i = 0; i < 100 && (exp_tok.size() != 0 || exp_w0.size() != 0); i++) stepCycle();
        checkOutput({tag, "_drain"}, 32'(exp_tok.size() + exp_w0.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1; ce_decode = 1'b0; tok_ready = 1'b0; tok_ready1 = 1'b1;
        refreshStream();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_tok_valid", 32'(tok_valid), 32'd0);
        checkOutput("rst_tok_copy", 32'(tok_copy), 32'd0);
        checkOutput("rst_tok_lit", 32'(tok_lit), 32'd0);
        checkOutput("rst_tok_off", 32'(tok_off), 32'd0);
        checkOutput("rst_tok_len", 32'(tok_len), 32'd0);
        checkOutput("rst_ack", 32'(stream_ack), 32'd0);
        checkOutput("rst_width", 32'(stream_width), 32'd0);
        checkOutput("rst_all_end", 32'(all_end), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_small", 32'({tok_copy1, tok_lit1, tok_off1, tok_len1, all_end1, err1}), 32'd0);
        rst = 1'b0;

        // Back-to-back literals at one per clock.
        tok_ready = 1'b1;
        foreach (lits[i]) begin
            applyStimulus(0, 32'({1'b0, lits[i]}), 9);
            expectLit(lits[i]);
        end
        tok_cycle.delete();
        ce_decode = 1'b1;
        waitDrain("literals");
        span = (tok_cycle.size() == 3) ? tok_cycle[2] - tok_cycle[0] : -1;
        checkOutput("lit_throughput", 32'(span), 32'd2);

        // Short copy, offset 5, length code 01.
        applyStimulus(0, 32'({2'b11, 7'd5, 2'b01}), 11);
        exp_w0.push_back(9); exp_w0.push_back(2);
        expectCopy(11'd5, 12'd3);
        waitDrain("short_copy");

        // Long copy, offset 0x400, length 8+15+3.
        applyStimulus(0, 32'({2'b10, 11'h400, 12'hFF3}), 25);
        exp_w0.push_back(13); exp_w0.push_back(2); exp_w0.push_back(2);
        exp_w0.push_back(4);  exp_w0.push_back(4);
        expectCopy(11'h400, 12'd26);
        waitDrain("long_copy");

        // Consumer stall with a literal, a copy and a further literal queued.
        tok_ready = 1'b0;
        applyStimulus(0, 32'({1'b0, 8'h55}), 9);
        expectLit(8'h55);
        applyStimulus(0, 32'({2'b11, 7'd3, 2'b00}), 11);
        exp_w0.push_back(9); exp_w0.push_back(2);
        expectCopy(11'd3, 12'd2);
        applyStimulus(0, 32'({1'b0, 8'h66}), 9);
        expectLit(8'h66);
        for (int i = 0; i < 5; i++) begin
            stepCycle();
            checkOutput("stall_tok_valid", 32'(tok_valid), 32'd1);
            checkOutput("stall_tok_lit", 32'(tok_lit), 32'h55);
        end
        checkOutput("stall_no_ack", 32'(stream_ack), 32'd0);
        checkOutput("stall_tok_copy", 32'(tok_copy), 32'd0);
        checkOutput("stall_bits_left", 32'(q0.size()), 32'd9);
        tok_ready = 1'b1;
        waitDrain("stall");

        // End marker, then drop enable.
        applyStimulus(0, 32'({2'b11, 7'd0}), 9);
        exp_w0.push_back(9);
        for (int i = 0; i < 20 && !all_end; i++) stepCycle();
        checkOutput("end_all_end", 32'(all_end), 32'd1);
        checkOutput("end_width_seen", 32'(exp_w0.size()), 32'd0);
        checkOutput("end_no_ack", 32'(stream_ack), 32'd0);
        checkOutput("end_err", 32'(err), 32'd0);
        ce_decode = 1'b0;
        stepCycle();
        checkOutput("end_idle", 32'(all_end), 32'd0);

        // Long offset of zero is malformed and is not acked.
        ce_decode = 1'b1;
        applyStimulus(0, 32'({2'b10, 11'd0}), 13);
        for (int i = 0; i < 20 && !err; i++) stepCycle();
        checkOutput("zero_off_err", 32'(err), 32'd1);
        checkOutput("zero_off_no_ack", 32'(stream_ack), 32'd0);
        checkOutput("zero_off_bits_left", 32'(q0.size()), 32'd13);
        ce_decode = 1'b0;
        stepCycle();
        checkOutput("err_idle", 32'(err), 32'd0);
        q0.delete();
        refreshStream();
        ce_decode = 1'b1;
        stepCycle();

        // Length overflow on the LEN_W=5 instance: 8+15 fits, the next +15 does not.
        applyStimulus(1, 32'({2'b11, 7'd1, 4'b1111, 8'hFF, 4'h0}), 25);
        exp_w1.push_back(9); exp_w1.push_back(2); exp_w1.push_back(2); exp_w1.push_back(4);
        for (int i = 0; i < 20 && !err1; i++) stepCycle();
        checkOutput("ovf_err", 32'(err1), 32'd1);
        checkOutput("ovf_widths_seen", 32'(exp_w1.size()), 32'd0);
        checkOutput("ovf_no_ack", 32'(stream_ack1), 32'd0);
        checkOutput("ovf_bits_left", 32'(q1.size()), 32'd8);

        // Reset while a literal is pending and a copy sits in LENX.
        tok_ready = 1'b0;
        applyStimulus(0, 32'({1'b0, 8'h77}), 9);
        exp_w0.push_back(9);
        applyStimulus(0, 32'({2'b11, 7'd2, 4'b1111}), 13);
        exp_w0.push_back(9); exp_w0.push_back(2); exp_w0.push_back(2);
        for (int i = 0; i < 7; i++) stepCycle();
        checkOutput("pre_rst_widths_seen", 32'(exp_w0.size()), 32'd0);
        checkOutput("pre_rst_tok_valid", 32'(tok_valid), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_tok_valid", 32'(tok_valid), 32'd0);
        checkOutput("mid_rst_tok_lit", 32'(tok_lit), 32'd0);
        checkOutput("mid_rst_ack", 32'(stream_ack), 32'd0);
        checkOutput("mid_rst_small_err", 32'(err1), 32'd0);
        q1.delete();
        ce_decode = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tok_ready = 1'b1;
        applyStimulus(0, 32'({1'b0, 8'h12}), 9);
        stepCycle();
        stepCycle();
        checkOutput("idle_no_pop", 32'(q0.size()), 32'd9);
        expectLit(8'h12);
        ce_decode = 1'b1;
        waitDrain("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
